wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have these ports, one clock domain, reset synchronous active-high:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- valid_i  in  1  ALU-stage instruction valid this cycle
- op_i  in  9  instruction; op_i[8:1] cast to shared op_code enum
- rd_i  in  2  destination register index
- result_i  in  8  ALU result
- cmp_i  in  8  ALU compare difference
- carry_i / neg_i / zero_i  in  1 each  ALU flags
- addr_i  in  8  data-memory address (LW/SW/ALW/ASW)
- sdata_i  in  8  store data
- mem_rdata_i  in  8  data-memory read data
- mem_ack_i  in  1  data-memory completion
- mem_req_o / mem_we_o  out  1 each  memory request / write select
- mem_addr_o / mem_wdata_o  out  8 each  memory address / write data
- rf_we_o  out  1  register-file write enable
- rf_waddr_o  out  2  write index
- rf_wdata_o  out  8  write data
- carry_q_o / neg_q_o / zero_q_o  out  1 each  registered flags (carry_q_o feeds ALU for ADDC/SUBC/LSLC/LSRC)
- stall_o  out  1  upstream hold request
- halt_o  out  1  processor halted

Function
REQ-002 SHALL implement FSM states IDLE, MEM_WAIT, HALTED; reset state IDLE.
REQ-003 In IDLE with valid_i=1, SHALL accept the instruction that cycle; with valid_i=0, outputs hold defaults.
REQ-004 ALU ops (ADD, ADDC, SUB, SUBC, LSL, LSLC, LSR, LSRC, ASR, NEG, AND, OR) SHALL assert rf_we_o combinationally in the accept cycle, rf_waddr_o=rd_i, rf_wdata_o=result_i; flags register at the next edge.
REQ-005 CMP SHALL NOT write the register file; SHALL latch flags with zero_q = (cmp_i==0), neg_q = cmp_i[7], carry_q = carry_i.
REQ-006 IMME, BLT, BNE SHALL write neither register file nor flags.
REQ-007 LW/ALW SHALL register mem_req_o=1, mem_we_o=0, mem_addr_o=addr_i, capture rd_i, and enter MEM_WAIT at the next edge.
REQ-008 SW/ASW SHALL register mem_req_o=1, mem_we_o=1, mem_addr_o=addr_i, mem_wdata_o=sdata_i, and enter MEM_WAIT.
REQ-009 In MEM_WAIT, mem_req_o and address/data SHALL stay stable until the cycle mem_ack_i=1; the next edge clears mem_req_o and returns to IDLE.
REQ-010 Load completion SHALL assert rf_we_o in the ack cycle with rf_wdata_o=mem_rdata_i, rf_waddr_o=captured rd; flags unchanged.
REQ-011 mem_ack_i outside MEM_WAIT SHALL be ignored.
REQ-012 stall_o SHALL be 1 in MEM_WAIT (including the ack cycle) and in HALTED; 0 otherwise. Upstream holds valid_i/op_i while stall_o=1; the stage ignores valid_i while stall_o=1.
REQ-013 Minimum memory latency: request visible one cycle after accept; ack in that first request cycle is legal (2-cycle instruction).
REQ-014 HALT SHALL enter HALTED at the next edge; halt_o=1 and all write/request outputs 0 until reset.
REQ-015 Unrecognised op codes SHALL behave as NOP.
REQ-016 Flag registers SHALL change only per REQ-004/005.

Reset
REQ-017 Reset SHALL force IDLE, and clear mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, carry/neg/zero flags, captured rd, halt_o, and stall_o to 0; rf_we_o=0 during reset.
REQ-018 Reset during MEM_WAIT SHALL drop the request at the next edge with no register write; a simultaneous mem_ack_i is discarded.
REQ-019 Reset SHALL release HALTED.

Structure
REQ-020 The op_code enum and a STATE typedef (IDLE, MEM_WAIT, HALTED) SHALL live in the shared definitions package; no local op encodings.
REQ-021 Flag storage SHALL be one sub-module flag_reg (8-bit-free, 3 flops, load enable, sync reset).

Verification
REQ-022 ADD, result_i=8'h80, carry_i=1, neg_i=1, rd_i=2 -> rf_we_o=1, waddr=2, wdata=8'h80 that cycle; next cycle carry_q=1, neg_q=1, zero_q=0.
REQ-023 CMP, cmp_i=8'h00 -> rf_we_o=0 throughout; zero_q=1 next cycle; prior register contents untouched.
REQ-024 LW, addr_i=8'h10, rd_i=1, ack 3 cycles after request with rdata=8'h5A -> mem_req_o high 3 cycles at addr 8'h10, stall_o high, rf write 8'h5A to r1 in ack cycle, IDLE next.
REQ-025 SW, addr_i=8'hFF, sdata_i=8'h33, ack in first request cycle -> single-cycle mem_req_o, mem_we_o=1, wdata 8'h33, no rf write, no flag change.
REQ-026 LW pending, reset asserted in ack cycle -> no rf write, mem_req_o=0, state IDLE, flags 0.
REQ-027 HALT then valid ADD -> halt_o=1, stall_o=1, ADD ignored; reset -> halt_o=0, ADD accepted.

Source files
------------

// File: rtl/wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_pkg
// Brief    : Shared op-code and writeback-stage state definitions.
// Revision : 1.0 - initial release
// ============================================================================
package wb_stage_pkg;

    typedef enum logic [7:0] {
        OP_NOP  = 8'h00,
        OP_ADD  = 8'h01,
        OP_ADDC = 8'h02,
        OP_SUB  = 8'h03,
        OP_SUBC = 8'h04,
        OP_LSL  = 8'h05,
        OP_LSLC = 8'h06,
        OP_LSR  = 8'h07,
        OP_LSRC = 8'h08,
        OP_ASR  = 8'h09,
        OP_NEG  = 8'h0A,
        OP_AND  = 8'h0B,
        OP_OR   = 8'h0C,
        OP_CMP  = 8'h0D,
        OP_IMME = 8'h0E,
        OP_BLT  = 8'h0F,
        OP_BNE  = 8'h10,
        OP_LW   = 8'h11,
        OP_SW   = 8'h12,
        OP_ALW  = 8'h13,
        OP_ASW  = 8'h14,
        OP_HALT = 8'h15
    } op_code_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } state_e;

    localparam int FLAG_W = 3;

    // Ops that write the register file and load all three ALU flags.
    function automatic logic is_alu_op(op_code_e op);
        return op inside {OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_LSL, OP_LSLC,
                          OP_LSR, OP_LSRC, OP_ASR, OP_NEG, OP_AND, OP_OR};
    endfunction

endpackage
`default_nettype wire

// File: rtl/flag_reg.sv
`default_nettype none
// ============================================================================
// Module   : flag_reg
// Brief    : Carry/negative/zero flag storage with load enable.
// Revision : 1.0 - initial release
// ============================================================================
module flag_reg
    import wb_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [FLAG_W-1:0] i_d,
    output logic [FLAG_W-1:0] o_q
);

    logic [FLAG_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Brief    : Writeback stage: register-file writes, flags, data-memory access.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_i,
    input  logic [8:0] op_i,
    input  logic [1:0] rd_i,
    input  logic [7:0] result_i,
    input  logic [7:0] cmp_i,
    input  logic       carry_i,
    input  logic       neg_i,
    input  logic       zero_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] sdata_i,
    input  logic [7:0] mem_rdata_i,
    input  logic       mem_ack_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic [7:0] mem_addr_o,
    output logic [7:0] mem_wdata_o,
    output logic       rf_we_o,
    output logic [1:0] rf_waddr_o,
    output logic [7:0] rf_wdata_o,
    output logic       carry_q_o,
    output logic       neg_q_o,
    output logic       zero_q_o,
    output logic       stall_o,
    output logic       halt_o
);

    state_e            r_state;
    state_e            w_state_nxt;
    op_code_e          w_op;
    logic              w_unused_op_lsb;
    logic              w_start_load;
    logic              w_start_store;
    logic              w_flag_en;
    logic [FLAG_W-1:0] w_flag_d;
    logic [FLAG_W-1:0] w_flag_q;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [7:0]        r_mem_addr;
    logic [7:0]        r_mem_wdata;
    logic [1:0]        r_rd;

    assign w_op            = op_code_e'(op_i[8:1]);
    assign w_unused_op_lsb = op_i[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_start_load  = 1'b0;
        w_start_store = 1'b0;
        w_flag_en     = 1'b0;
        w_flag_d      = {carry_i, neg_i, zero_i};
        rf_we_o       = 1'b0;
        rf_waddr_o    = rd_i;
        rf_wdata_o    = result_i;
        case (r_state)
            ST_IDLE: begin
                if (valid_i) begin
                    if (is_alu_op(w_op)) begin
                        rf_we_o   = 1'b1;
                        w_flag_en = 1'b1;
                    end else begin
                        case (w_op)
                            OP_CMP: begin
                                w_flag_en = 1'b1;
                                w_flag_d  = {carry_i, cmp_i[7], (cmp_i == 8'h00)};
                            end
                            OP_LW, OP_ALW: begin
                                w_start_load = 1'b1;
                                w_state_nxt  = ST_MEM_WAIT;
                            end
                            OP_SW, OP_ASW: begin
                                w_start_store = 1'b1;
                                w_state_nxt   = ST_MEM_WAIT;
                            end
                            OP_HALT: w_state_nxt = ST_HALTED;
                            default: ;
                        endcase
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ack_i) begin
                    w_state_nxt = ST_IDLE;
                    if (!r_mem_we) begin
                        rf_we_o    = 1'b1;
                        rf_waddr_o = r_rd;
                        rf_wdata_o = mem_rdata_i;
                    end
                end
            end
            ST_HALTED: ;
            default: w_state_nxt = ST_IDLE;
        endcase
        // A reset cycle must never commit anything, including a late load ack.
        if (reset) begin
            rf_we_o   = 1'b0;
            w_flag_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 8'h00;
            r_mem_wdata <= 8'h00;
            r_rd        <= 2'd0;
        end else if (w_start_load) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= addr_i;
            r_rd       <= rd_i;
        end else if (w_start_store) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= addr_i;
            r_mem_wdata <= sdata_i;
        end else if ((r_state == ST_MEM_WAIT) && mem_ack_i) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
        end
    end

    flag_reg u_flag_reg (
        .clk  (clk),
        .rst  (reset),
        .i_en (w_flag_en),
        .i_d  (w_flag_d),
        .o_q  (w_flag_q)
    );

    assign {carry_q_o, neg_q_o, zero_q_o} = w_flag_q;

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign stall_o     = (r_state == ST_MEM_WAIT) || (r_state == ST_HALTED);
    assign halt_o      = (r_state == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Brief    : Table vectors, directed memory/halt sequences and random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid_i = 1'b0;
    logic [8:0] op_i = '0;
    logic [1:0] rd_i = '0;
    logic [7:0] result_i = '0, cmp_i = '0, addr_i = '0, sdata_i = '0, mem_rdata_i = '0;
    logic       carry_i = 1'b0, neg_i = 1'b0, zero_i = 1'b0, mem_ack_i = 1'b0;
    logic       mem_req_o, mem_we_o, rf_we_o, carry_q_o, neg_q_o, zero_q_o, stall_o, halt_o;
    logic [7:0] mem_addr_o, mem_wdata_o, rf_wdata_o;
    logic [1:0] rf_waddr_o;

    wb_stage dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .op_i(op_i), .rd_i(rd_i),
        .result_i(result_i), .cmp_i(cmp_i), .carry_i(carry_i), .neg_i(neg_i),
        .zero_i(zero_i), .addr_i(addr_i), .sdata_i(sdata_i), .mem_rdata_i(mem_rdata_i),
        .mem_ack_i(mem_ack_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .rf_we_o(rf_we_o),
        .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .carry_q_o(carry_q_o),
        .neg_q_o(neg_q_o), .zero_q_o(zero_q_o), .stall_o(stall_o), .halt_o(halt_o)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Transaction-level reference: is the stage busy with memory, halted, and what is pending.
    bit         m_halted, m_wait, m_store, m_req;
    logic [7:0] m_addr, m_wdata;
    logic [1:0] m_rd;
    logic [2:0] m_flags;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic bit is_alu(input logic [7:0] op);
        return op inside {OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_LSL, OP_LSLC,
                          OP_LSR, OP_LSRC, OP_ASR, OP_NEG, OP_AND, OP_OR};
    endfunction

    // One clock: compare outputs against the model mid-cycle, then advance the model at the edge.
    task automatic cyc();
        logic       exp_we;
        logic [1:0] exp_wa;
        logic [7:0] exp_wd, op;
        @(negedge clk);
        op = op_i[8:1];
        exp_we = 1'b0; exp_wa = 2'd0; exp_wd = 8'h00;
        if (!reset) begin
            if (m_wait && mem_ack_i && !m_store) begin
                exp_we = 1'b1; exp_wa = m_rd; exp_wd = mem_rdata_i;
            end else if (!m_wait && !m_halted && valid_i && is_alu(op)) begin
                exp_we = 1'b1; exp_wa = rd_i; exp_wd = result_i;
            end
        end
        chk("m_rf_we", rf_we_o, exp_we);
        if (exp_we) begin
            chk("m_rf_waddr", rf_waddr_o, exp_wa);
            chk("m_rf_wdata", rf_wdata_o, exp_wd);
        end
        chk("m_stall", stall_o, m_wait || m_halted);
        chk("m_halt", halt_o, m_halted);
        chk("m_mem_req", mem_req_o, m_req);
        if (m_req) begin
            chk("m_mem_we", mem_we_o, m_store);
            chk("m_mem_addr", mem_addr_o, m_addr);
            if (m_store) chk("m_mem_wdata", mem_wdata_o, m_wdata);
        end
        chk("m_flags", {carry_q_o, neg_q_o, zero_q_o}, m_flags);
        @(posedge clk);
        if (reset) begin
            m_halted = 0; m_wait = 0; m_store = 0; m_req = 0; m_flags = '0;
        end else if (m_halted) begin
        end else if (m_wait) begin
            if (mem_ack_i) begin m_wait = 0; m_req = 0; end
        end else if (valid_i) begin
            if (is_alu(op)) m_flags = {carry_i, neg_i, zero_i};
            else if (op == OP_CMP) m_flags = {carry_i, cmp_i[7], cmp_i == 8'h00};
            else if (op == OP_LW || op == OP_ALW) begin
                m_wait = 1; m_req = 1; m_store = 0; m_addr = addr_i; m_rd = rd_i;
            end else if (op == OP_SW || op == OP_ASW) begin
                m_wait = 1; m_req = 1; m_store = 1; m_addr = addr_i; m_wdata = sdata_i;
            end else if (op == OP_HALT) m_halted = 1;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; valid_i = 1'b0; mem_ack_i = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    task automatic set_op(input logic [7:0] op);
        op_i = {op, 1'b0};
    endtask

    typedef struct {
        logic       valid;
        logic [7:0] op;
        logic [1:0] rd;
        logic [7:0] res, cmp;
        logic       c, n, z;
        logic       ex_we;
        logic [7:0] ex_wd;
        logic [2:0] ex_fl;
    } vec_t;

    vec_t       vt[14];
    logic [7:0] ops[20];

    initial begin
        vt[0]  = '{1'b1, OP_ADD,  2'd2, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 3'b110};
        vt[1]  = '{1'b1, OP_CMP,  2'd3, 8'h55, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'b001};
        vt[2]  = '{1'b1, OP_CMP,  2'd1, 8'h00, 8'h85, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'b110};
        vt[3]  = '{1'b1, OP_SUB,  2'd3, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 3'b001};
        vt[4]  = '{1'b1, OP_LSLC, 2'd0, 8'h7E, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h7E, 3'b100};
        vt[5]  = '{1'b1, OP_IMME, 2'd2, 8'h12, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 3'b000};
        vt[6]  = '{1'b1, OP_BLT,  2'd1, 8'h34, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 3'b000};
        vt[7]  = '{1'b1, OP_BNE,  2'd1, 8'h34, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'b000};
        vt[8]  = '{1'b1, 8'hEE,   2'd2, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 3'b000};
        vt[9]  = '{1'b1, OP_OR,   2'd1, 8'hF0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hF0, 3'b010};
        vt[10] = '{1'b1, OP_NEG,  2'd0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 3'b101};
        vt[11] = '{1'b0, OP_ADD,  2'd2, 8'h99, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 3'b000};
        vt[12] = '{1'b1, OP_ASR,  2'd3, 8'hC0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hC0, 3'b010};
        vt[13] = '{1'b1, OP_NOP,  2'd3, 8'h11, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 3'b000};
        ops = '{OP_NOP, OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_LSL, OP_LSLC, OP_LSR, OP_LSRC,
                OP_ASR, OP_NEG, OP_AND, OP_OR, OP_CMP, OP_IMME, OP_BLT, OP_BNE,
                OP_LW, OP_SW, OP_ALW};

        // Power-up: DUT state is unknown until the first reset edge.
        valid_i = 1'b1; set_op(OP_ADD);
        @(posedge clk); #1;
        m_halted = 0; m_wait = 0; m_store = 0; m_req = 0; m_flags = '0; m_rd = '0;
        m_addr = '0; m_wdata = '0;
        chk("rst_rf_we", rf_we_o, 1'b0);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_halt", halt_o, 1'b0);
        chk("rst_req", mem_req_o, 1'b0);
        chk("rst_addr", mem_addr_o, 8'h00);
        chk("rst_flags", {carry_q_o, neg_q_o, zero_q_o}, 3'b000);
        valid_i = 1'b0;

        // Single-instruction vectors, each from a fresh reset.
        for (int i = 0; i < 14; i++) begin
            do_reset();
            valid_i = vt[i].valid; set_op(vt[i].op); rd_i = vt[i].rd;
            result_i = vt[i].res; cmp_i = vt[i].cmp;
            carry_i = vt[i].c; neg_i = vt[i].n; zero_i = vt[i].z;
            #1;
            chk($sformatf("vec%0d_rf_we", i), rf_we_o, vt[i].ex_we);
            if (vt[i].ex_we) begin
                chk($sformatf("vec%0d_waddr", i), rf_waddr_o, vt[i].rd);
                chk($sformatf("vec%0d_wdata", i), rf_wdata_o, vt[i].ex_wd);
            end
            cyc();
            valid_i = 1'b0; #1;
            chk($sformatf("vec%0d_flags", i), {carry_q_o, neg_q_o, zero_q_o}, vt[i].ex_fl);
            chk($sformatf("vec%0d_stall", i), stall_o, 1'b0);
        end

        // Load with ack on the third request cycle.
        do_reset();
        valid_i = 1'b1; set_op(OP_LW); addr_i = 8'h10; rd_i = 2'd1; mem_rdata_i = 8'h5A;
        #1; chk("lw_accept_req", mem_req_o, 1'b0);
        cyc();
        valid_i = 1'b0; addr_i = 8'h77; rd_i = 2'd3;
        for (int k = 0; k < 3; k++) begin
            mem_ack_i = (k == 2); #1;
            chk("lw_req", mem_req_o, 1'b1);
            chk("lw_addr", mem_addr_o, 8'h10);
            chk("lw_stall", stall_o, 1'b1);
            chk("lw_rf_we", rf_we_o, k == 2);
            if (k == 2) begin
                chk("lw_waddr", rf_waddr_o, 2'd1);
                chk("lw_wdata", rf_wdata_o, 8'h5A);
            end
            cyc();
        end
        mem_ack_i = 1'b0; #1;
        chk("lw_done_req", mem_req_o, 1'b0);
        chk("lw_done_stall", stall_o, 1'b0);

        // Store acked in its first request cycle, flags preset to 101.
        do_reset();
        valid_i = 1'b1; set_op(OP_ADD); carry_i = 1'b1; neg_i = 1'b0; zero_i = 1'b1;
        cyc();
        set_op(OP_SW); addr_i = 8'hFF; sdata_i = 8'h33; carry_i = 1'b0; zero_i = 1'b0;
        cyc();
        valid_i = 1'b0; mem_ack_i = 1'b1; #1;
        chk("sw_req", mem_req_o, 1'b1);
        chk("sw_we", mem_we_o, 1'b1);
        chk("sw_addr", mem_addr_o, 8'hFF);
        chk("sw_wdata", mem_wdata_o, 8'h33);
        chk("sw_rf_we", rf_we_o, 1'b0);
        cyc();
        mem_ack_i = 1'b0; #1;
        chk("sw_done_req", mem_req_o, 1'b0);
        chk("sw_flags", {carry_q_o, neg_q_o, zero_q_o}, 3'b101);

        // Reset landing on the load ack cycle.
        do_reset();
        valid_i = 1'b1; set_op(OP_LW); addr_i = 8'h20; rd_i = 2'd2;
        cyc();
        valid_i = 1'b0;
        cyc();
        mem_ack_i = 1'b1; reset = 1'b1; #1;
        chk("rstack_rf_we", rf_we_o, 1'b0);
        cyc();
        reset = 1'b0; mem_ack_i = 1'b0; #1;
        chk("rstack_req", mem_req_o, 1'b0);
        chk("rstack_stall", stall_o, 1'b0);
        chk("rstack_flags", {carry_q_o, neg_q_o, zero_q_o}, 3'b000);

        // HALT blocks later work until reset.
        do_reset();
        valid_i = 1'b1; set_op(OP_HALT);
        cyc();
        set_op(OP_ADD); rd_i = 2'd0; result_i = 8'h42;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("halt_halt", halt_o, 1'b1);
            chk("halt_stall", stall_o, 1'b1);
            chk("halt_rf_we", rf_we_o, 1'b0);
            cyc();
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0; #1;
        chk("unhalt_halt", halt_o, 1'b0);
        chk("unhalt_rf_we", rf_we_o, 1'b1);
        chk("unhalt_wdata", rf_wdata_o, 8'h42);
        cyc();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            valid_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) set_op(OP_HALT);
            else if ($urandom_range(0, 9) == 0) op_i = 9'($urandom);
            else op_i = {ops[$urandom_range(0, 19)], 1'($urandom)};
            if (op_i[8:1] == OP_LW && $urandom_range(0, 1) == 1) set_op(OP_ASW);
            rd_i = 2'($urandom); result_i = 8'($urandom); cmp_i = 8'($urandom);
            if ($urandom_range(0, 3) == 0) cmp_i = 8'h00;
            carry_i = 1'($urandom); neg_i = 1'($urandom); zero_i = 1'($urandom);
            addr_i = 8'($urandom); sdata_i = 8'($urandom); mem_rdata_i = 8'($urandom);
            mem_ack_i = ($urandom_range(0, 2) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
